cec_message_parser: RTL and testbench

Receive-side counterpart of the CEC message generator: consumes byte frames delivered by the CEC bit-level receiver, decodes header/opcode/operands, filters by logical address, and drives the per-byte ACK decision back to the bit layer. Delivers each complete message addressed to this device, or broadcast, as a one-cycle strobe with stable fields, for the control FSM that answers requests such as Give Physical Address.

---
 rtl/cec_pkg.sv | 18 +
 rtl/cec_message_parser.sv | 230 +++++++++++++++++++++++
 tb/tb_cec_message_parser.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cec_pkg.sv
// Shared CEC definitions: broadcast address, common opcodes, parser states.
package cec_pkg;

    localparam logic [3:0] CEC_BROADCAST_ADDR = 4'hF;

    localparam logic [7:0] IMAGE_VIEW_ON           = 8'h04;
    localparam logic [7:0] GIVE_PHYSICAL_ADDRESS   = 8'h83;
    localparam logic [7:0] REPORT_PHYSICAL_ADDRESS = 8'h84;

    // IDLE expects a header; SKIP drains a frame addressed to someone else.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPCODE = 2'd1,
        ST_PARAMS = 2'd2,
        ST_SKIP   = 2'd3
    } state_t;

endpackage

// File: rtl/cec_message_parser.sv
// CEC receive-side message parser: decodes header/opcode/operands from the
// bit-level receiver, filters on logical address, drives the ACK decision and
// delivers accepted messages as a one-cycle strobe with held fields.
module cec_message_parser
    import cec_pkg::*;
#(
    parameter logic [3:0] LOGICAL_ADDR = 4'd14,
    parameter int         MAX_PARAMS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_eom,
    input  logic                    rx_valid,
    input  logic                    rx_start,
    input  logic                    rx_error,
    output logic                    ack_assert,
    output logic                    msg_valid,
    output logic [3:0]              msg_src,
    output logic [3:0]              msg_dst,
    output logic                    msg_broadcast,
    output logic                    msg_has_opcode,
    output logic [7:0]              msg_opcode,
    output logic [8*MAX_PARAMS-1:0] msg_params,
    output logic [3:0]              msg_param_count,
    output logic                    msg_overflow
);

    // Working message, built up byte by byte while a frame is in flight
    state_t     state_reg;
    logic [3:0] work_src_reg;
    logic [3:0] work_dst_reg;
    logic [7:0] work_opcode_reg;
    logic [7:0] work_params_reg [MAX_PARAMS];
    logic [3:0] work_count_reg;
    logic       work_overflow_reg;

    // Delivered message, held until the next accepted message
    logic       ack_reg;
    logic       msg_valid_reg;
    logic [3:0] msg_src_reg;
    logic [3:0] msg_dst_reg;
    logic       msg_has_opcode_reg;
    logic [7:0] msg_opcode_reg;
    logic [7:0] msg_params_reg [MAX_PARAMS];
    logic [3:0] msg_count_reg;
    logic       msg_overflow_reg;

    // Operand store after the current byte, and the fields an emit would carry
    logic [7:0] params_next [MAX_PARAMS];
    logic [3:0] count_next;
    logic       overflow_next;

    logic       byte_accepted;
    logic       header_hit;
    logic       emit_now;
    logic [3:0] emit_src;
    logic [3:0] emit_dst;
    logic       emit_has_opcode;
    logic [7:0] emit_opcode;
    logic [7:0] emit_params [MAX_PARAMS];
    logic [3:0] emit_count;
    logic       emit_overflow;

    // Errors and new start bits pre-empt any byte arriving in the same cycle
    assign byte_accepted = rx_valid && !rx_error && !rx_start;
    assign header_hit    = (rx_data[3:0] == LOGICAL_ADDR) ||
                           (rx_data[3:0] == CEC_BROADCAST_ADDR);

    // Operand store update: append while room remains, else flag overflow
    always_comb begin
        for (int i = 0; i < MAX_PARAMS; i++) begin
            params_next[i] = work_params_reg[i];
            if (work_count_reg == 4'(i)) begin
                params_next[i] = rx_data;
            end
        end
        if (work_count_reg < 4'(MAX_PARAMS)) begin
            count_next    = work_count_reg + 4'd1;
            overflow_next = work_overflow_reg;
        end else begin
            count_next    = work_count_reg;
            overflow_next = 1'b1;
        end
    end

    // Fields of the message completed by the current EOM byte, per state
    always_comb begin
        emit_now        = 1'b0;
        emit_src        = work_src_reg;
        emit_dst        = work_dst_reg;
        emit_has_opcode = 1'b1;
        emit_opcode     = work_opcode_reg;
        emit_count      = work_count_reg;
        emit_overflow   = work_overflow_reg;
        for (int i = 0; i < MAX_PARAMS; i++) begin
            emit_params[i] = work_params_reg[i];
        end
        unique case (state_reg)
            ST_IDLE: begin
                emit_now        = byte_accepted && rx_eom && header_hit;
                emit_src        = rx_data[7:4];
                emit_dst        = rx_data[3:0];
                emit_has_opcode = 1'b0;
                emit_opcode     = 8'h00;
                emit_count      = 4'd0;
                emit_overflow   = 1'b0;
                for (int i = 0; i < MAX_PARAMS; i++) begin
                    emit_params[i] = 8'h00;
                end
            end
            ST_OPCODE: begin
                emit_now    = byte_accepted && rx_eom;
                emit_opcode = rx_data;
            end
            ST_PARAMS: begin
                emit_now      = byte_accepted && rx_eom;
                emit_count    = count_next;
                emit_overflow = overflow_next;
                for (int i = 0; i < MAX_PARAMS; i++) begin
                    emit_params[i] = params_next[i];
                end
            end
            default: emit_now = 1'b0;
        endcase
    end

    // Frame FSM, ACK decision and message delivery registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            work_src_reg       <= 4'd0;
            work_dst_reg       <= 4'd0;
            work_opcode_reg    <= 8'h00;
            work_count_reg     <= 4'd0;
            work_overflow_reg  <= 1'b0;
            ack_reg            <= 1'b0;
            msg_valid_reg      <= 1'b0;
            msg_src_reg        <= 4'd0;
            msg_dst_reg        <= 4'd0;
            msg_has_opcode_reg <= 1'b0;
            msg_opcode_reg     <= 8'h00;
            msg_count_reg      <= 4'd0;
            msg_overflow_reg   <= 1'b0;
            for (int i = 0; i < MAX_PARAMS; i++) begin
                work_params_reg[i] <= 8'h00;
                msg_params_reg[i]  <= 8'h00;
            end
        end else begin
            msg_valid_reg <= 1'b0;
            if (rx_error || rx_start) begin
                // Abort or restart: any partial frame is dropped, ACK released
                state_reg <= ST_IDLE;
                ack_reg   <= 1'b0;
            end else if (rx_valid) begin
                unique case (state_reg)
                    ST_IDLE: begin
                        work_src_reg      <= rx_data[7:4];
                        work_dst_reg      <= rx_data[3:0];
                        work_opcode_reg   <= 8'h00;
                        work_count_reg    <= 4'd0;
                        work_overflow_reg <= 1'b0;
                        for (int i = 0; i < MAX_PARAMS; i++) begin
                            work_params_reg[i] <= 8'h00;
                        end
                        ack_reg <= (rx_data[3:0] == LOGICAL_ADDR);
                        if (rx_eom) begin
                            state_reg <= ST_IDLE;
                        end else if (header_hit) begin
                            state_reg <= ST_OPCODE;
                        end else begin
                            state_reg <= ST_SKIP;
                        end
                    end
                    ST_OPCODE: begin
                        work_opcode_reg <= rx_data;
                        ack_reg         <= (work_dst_reg == LOGICAL_ADDR);
                        state_reg       <= rx_eom ? ST_IDLE : ST_PARAMS;
                    end
                    ST_PARAMS: begin
                        work_count_reg    <= count_next;
                        work_overflow_reg <= overflow_next;
                        for (int i = 0; i < MAX_PARAMS; i++) begin
                            work_params_reg[i] <= params_next[i];
                        end
                        ack_reg <= (work_dst_reg == LOGICAL_ADDR);
                        if (rx_eom) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        ack_reg <= 1'b0;
                        if (rx_eom) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                endcase
            end

            if (emit_now) begin
                msg_valid_reg      <= 1'b1;
                msg_src_reg        <= emit_src;
                msg_dst_reg        <= emit_dst;
                msg_has_opcode_reg <= emit_has_opcode;
                msg_opcode_reg     <= emit_opcode;
                msg_count_reg      <= emit_count;
                msg_overflow_reg   <= emit_overflow;
                for (int i = 0; i < MAX_PARAMS; i++) begin
                    msg_params_reg[i] <= emit_params[i];
                end
            end
        end
    end

    // Flatten the delivered operand array onto the output bus
    for (genvar gi = 0; gi < MAX_PARAMS; gi++) begin : g_params
        assign msg_params[8*gi +: 8] = msg_params_reg[gi];
    end

    assign ack_assert      = ack_reg;
    assign msg_valid       = msg_valid_reg;
    assign msg_src         = msg_src_reg;
    assign msg_dst         = msg_dst_reg;
    assign msg_broadcast   = (msg_dst_reg == CEC_BROADCAST_ADDR);
    assign msg_has_opcode  = msg_has_opcode_reg;
    assign msg_opcode      = msg_opcode_reg;
    assign msg_param_count = msg_count_reg;
    assign msg_overflow    = msg_overflow_reg;

endmodule

// File: tb/tb_cec_message_parser.sv
// Directed bench for cec_message_parser with hand-computed expectations.
module tb_cec_message_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_eom = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_start = 1'b0;
    logic        rx_error = 1'b0;
    logic        ack_assert;
    logic        msg_valid;
    logic [3:0]  msg_src;
    logic [3:0]  msg_dst;
    logic        msg_broadcast;
    logic        msg_has_opcode;
    logic [7:0]  msg_opcode;
    logic [31:0] msg_params;
    logic [3:0]  msg_param_count;
    logic        msg_overflow;

    int checks = 0;
    int errors = 0;

    cec_message_parser #(.LOGICAL_ADDR(4'd14), .MAX_PARAMS(4)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_eom(rx_eom), .rx_valid(rx_valid),
        .rx_start(rx_start), .rx_error(rx_error),
        .ack_assert(ack_assert), .msg_valid(msg_valid),
        .msg_src(msg_src), .msg_dst(msg_dst), .msg_broadcast(msg_broadcast),
        .msg_has_opcode(msg_has_opcode), .msg_opcode(msg_opcode),
        .msg_params(msg_params), .msg_param_count(msg_param_count),
        .msg_overflow(msg_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte strobe; returns 1 time unit after the edge that consumed it
    task automatic send_byte(input logic [7:0] d, input logic e);
        @(posedge clk); #1;
        rx_data = d; rx_eom = e; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_eom = 1'b0;
        $display("byte %02h eom=%0d -> ack=%0d msg_valid=%0d", d, e, ack_assert, msg_valid);
    endtask

    task automatic pulse(input logic err, input logic st);
        @(posedge clk); #1;
        rx_error = err; rx_start = st;
        @(posedge clk); #1;
        rx_error = 1'b0; rx_start = 1'b0;
        $display("strobe err=%0d start=%0d -> ack=%0d msg_valid=%0d", err, st, ack_assert, msg_valid);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, ack_assert, 0);
        check({tag, "_valid"}, msg_valid, 0);
        check({tag, "_src_dst"}, {msg_src, msg_dst}, 0);
        check({tag, "_bcast"}, msg_broadcast, 0);
        check({tag, "_hasop"}, msg_has_opcode, 0);
        check({tag, "_opcode"}, msg_opcode, 0);
        check({tag, "_params"}, msg_params, 0);
        check({tag, "_count"}, msg_param_count, 0);
        check({tag, "_ovf"}, msg_overflow, 0);
    endtask

    initial begin
        // Reset state
        #12; rst = 1'b0;
        #10;
        check_reset_outputs("reset");

        // Polling message to us
        send_byte(8'h0E, 1'b1);
        check("poll_ack", ack_assert, 1);
        check("poll_valid", msg_valid, 1);
        check("poll_src", msg_src, 4'h0);
        check("poll_dst", msg_dst, 4'hE);
        check("poll_hasop", msg_has_opcode, 0);
        check("poll_count", msg_param_count, 0);
        check("poll_bcast", msg_broadcast, 0);
        @(posedge clk); #1;
        check("poll_valid_once", msg_valid, 0);
        check("poll_ack_hold", ack_assert, 1);
        pulse(1'b0, 1'b1);
        check("idle_start_ack", ack_assert, 0);

        // Give Physical Address
        send_byte(8'h0E, 1'b0);
        check("gpa_hdr_ack", ack_assert, 1);
        check("gpa_hdr_valid", msg_valid, 0);
        send_byte(8'h83, 1'b1);
        check("gpa_ack", ack_assert, 1);
        check("gpa_valid", msg_valid, 1);
        check("gpa_opcode", msg_opcode, 8'h83);
        check("gpa_hasop", msg_has_opcode, 1);
        check("gpa_count", msg_param_count, 0);

        // Broadcast Report Physical Address
        send_byte(8'h4F, 1'b0);
        check("bc_ack0", ack_assert, 0);
        send_byte(8'h84, 1'b0);
        check("bc_ack1", ack_assert, 0);
        send_byte(8'h10, 1'b0);
        check("bc_ack2", ack_assert, 0);
        send_byte(8'h00, 1'b0);
        check("bc_ack3", ack_assert, 0);
        send_byte(8'h04, 1'b1);
        check("bc_ack4", ack_assert, 0);
        check("bc_valid", msg_valid, 1);
        check("bc_bcast", msg_broadcast, 1);
        check("bc_src", msg_src, 4'h4);
        check("bc_dst", msg_dst, 4'hF);
        check("bc_opcode", msg_opcode, 8'h84);
        check("bc_params", msg_params, 32'h0004_0010);
        check("bc_count", msg_param_count, 3);
        check("bc_ovf", msg_overflow, 0);

        // Six operands into a four-entry store
        send_byte(8'h3E, 1'b0);
        send_byte(8'h84, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("ovf_ack_mid", ack_assert, 1);
        send_byte(8'h55, 1'b0);
        check("ovf_valid_mid", msg_valid, 0);
        send_byte(8'h66, 1'b1);
        check("ovf_valid", msg_valid, 1);
        check("ovf_src", msg_src, 4'h3);
        check("ovf_count", msg_param_count, 4);
        check("ovf_params", msg_params, 32'h4433_2211);
        check("ovf_flag", msg_overflow, 1);
        check("ovf_bcast", msg_broadcast, 0);

        // Foreign frame: no ACK, no message, fields held
        send_byte(8'h05, 1'b0);
        check("skip_ack0", ack_assert, 0);
        check("skip_valid0", msg_valid, 0);
        send_byte(8'h83, 1'b0);
        check("skip_ack1", ack_assert, 0);
        send_byte(8'h12, 1'b0);
        check("skip_valid2", msg_valid, 0);
        send_byte(8'h34, 1'b1);
        check("skip_ack3", ack_assert, 0);
        check("skip_valid3", msg_valid, 0);
        check("skip_hold_opcode", msg_opcode, 8'h84);
        send_byte(8'h2E, 1'b0);
        send_byte(8'h04, 1'b1);
        check("after_skip_valid", msg_valid, 1);
        check("after_skip_src", msg_src, 4'h2);
        check("after_skip_opcode", msg_opcode, 8'h04);
        check("after_skip_count", msg_param_count, 0);
        check("after_skip_ovf", msg_overflow, 0);

        // rx_error mid-frame; 0x83 then parses as a foreign header
        send_byte(8'h0E, 1'b0);
        pulse(1'b1, 1'b0);
        check("err_ack", ack_assert, 0);
        send_byte(8'h83, 1'b1);
        check("err_valid", msg_valid, 0);
        send_byte(8'h1E, 1'b1);
        check("err_next_valid", msg_valid, 1);
        check("err_next_src", msg_src, 4'h1);
        check("err_next_hasop", msg_has_opcode, 0);

        // rx_start mid-frame
        send_byte(8'h0E, 1'b0);
        send_byte(8'h83, 1'b0);
        pulse(1'b0, 1'b1);
        check("start_ack", ack_assert, 0);
        check("start_valid", msg_valid, 0);
        send_byte(8'h5E, 1'b1);
        check("start_next_valid", msg_valid, 1);
        check("start_next_src", msg_src, 4'h5);

        // rx_error in the same cycle as an EOM byte
        send_byte(8'h0E, 1'b0);
        @(posedge clk); #1;
        rx_data = 8'h83; rx_eom = 1'b1; rx_valid = 1'b1; rx_error = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_eom = 1'b0; rx_error = 1'b0;
        $display("byte 83 eom=1 with error -> ack=%0d msg_valid=%0d", ack_assert, msg_valid);
        check("coll_valid", msg_valid, 0);
        check("coll_ack", ack_assert, 0);
        check("coll_hold_src", msg_src, 4'h5);

        // Asynchronous reset mid-frame
        send_byte(8'h0E, 1'b0);
        #2; rst = 1'b1; #1;
        check_reset_outputs("arst");
        #4; rst = 1'b0;
        send_byte(8'h83, 1'b1);
        check("arst_valid", msg_valid, 0);
        check("arst_ack", ack_assert, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
